// File: rtl/dac_ramp_gate_pkg.sv
// Shared types and constants for the DAC output ramp gate.
package dac_ramp_gate_pkg;

   localparam int GAIN_W   = 16;
   localparam int SAMPLE_W = 16;

   // Unity gain in Q1.15.
   localparam logic [GAIN_W-1:0] GAIN_ONE = 16'h8000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      ON        = 2'd2,
      RAMP_DOWN = 2'd3
   } gate_state_t;

endpackage

// File: rtl/dac_lane_scale.sv
// One lane of the gain pipeline: stage 1 registers the signed product of the
// sample and the Q1.15 gain, stage 2 registers the rounded, saturated result.
// Both stages advance only when adv_i is high.
module dac_lane_scale
   import dac_ramp_gate_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                adv_i,
   input  logic [SAMPLE_W-1:0] din_i,
   input  logic [GAIN_W-1:0]   gain_i,
   output logic [SAMPLE_W-1:0] dout_o
);

   localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
   localparam int FRAC   = 15;
   localparam logic signed [PROD_W:0] RND_HALF = (PROD_W+1)'(2**(FRAC-1));
   localparam logic signed [PROD_W:0] SAT_MAX  = (PROD_W+1)'(2**(SAMPLE_W-1) - 1);
   localparam logic signed [PROD_W:0] SAT_MIN  = -(PROD_W+1)'(2**(SAMPLE_W-1));

   logic signed [SAMPLE_W-1:0] din_s;
   logic signed [GAIN_W:0]     gain_s;
   logic signed [PROD_W-1:0]   prod_p0;
   logic signed [PROD_W-1:0]   prod_p1_q;
   logic signed [SAMPLE_W-1:0] out_p2_d;
   logic signed [SAMPLE_W-1:0] out_p2_q;

   // Round half up, drop the Q1.15 fraction, clamp to the sample range.
   function automatic logic signed [SAMPLE_W-1:0] round_sat(input logic signed [PROD_W-1:0] p);
      logic signed [PROD_W:0] r;
      logic signed [PROD_W:0] q;
      r = (PROD_W+1)'(p) + RND_HALF;
      q = r >>> FRAC;
      if (q > SAT_MAX) begin
         round_sat = SAT_MAX[SAMPLE_W-1:0];
      end else if (q < SAT_MIN) begin
         round_sat = SAT_MIN[SAMPLE_W-1:0];
      end else begin
         round_sat = q[SAMPLE_W-1:0];
      end
   endfunction

   // Gain is unsigned, so it enters the signed multiply with a zero sign bit.
   assign din_s   = din_i;
   assign gain_s  = {1'b0, gain_i};
   assign prod_p0 = PROD_W'(din_s) * PROD_W'(gain_s);

   // Stage 2 next value: rounded and saturated product.
   always_comb begin
      out_p2_d = round_sat(prod_p1_q);
   end

   // Stage 1 -> stage 2 pipeline, frozen while the DAC stalls.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prod_p1_q <= '0;
         out_p2_q  <= '0;
      end else if (adv_i) begin
         prod_p1_q <= prod_p0;
         out_p2_q  <= out_p2_d;
      end
   end

   assign dout_o = out_p2_q;

endmodule

// File: rtl/dac_ramp_gate.sv
// Per-channel soft on/off gain ramp in front of a DAC AXI-Stream port.
// Optional feature macro: DAC_RAMP_GATE_DROP_CNT_EN enables the stall drop
// counter; without it drop_count is tied to zero.
module dac_ramp_gate
   import dac_ramp_gate_pkg::*;
#(
   parameter int NUMBER_OF_LINE = 8
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [16*NUMBER_OF_LINE-1:0]   din,
   input  logic                           enable,
   input  logic [15:0]                    ramp_step,
   output logic [16*NUMBER_OF_LINE-1:0]   m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic [1:0]                     gate_state,
   output logic [15:0]                    drop_count
);

   logic              adv;
   gate_state_t       state_q, state_d;
   logic [GAIN_W-1:0] g_q, g_d;
   logic              vld_p1_q;
   logic              vld_p2_q;
   logic [GAIN_W:0]   step_eff;
   logic [GAIN_W:0]   up_sum;

   // The whole block moves forward only when the output slot is free or taken.
   assign adv      = m_axis_tready | ~vld_p2_q;
   assign step_eff = (ramp_step == '0) ? (GAIN_W+1)'(1) : {1'b0, ramp_step};
   assign up_sum   = {1'b0, g_q} + step_eff;

   // Ramp FSM: direction reversals keep the current gain so the output never steps.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = RAMP_UP;
         end
         RAMP_UP: begin
            if (!enable) begin
               state_d = RAMP_DOWN;
            end else if (up_sum >= {1'b0, GAIN_ONE}) begin
               g_d     = GAIN_ONE;
               state_d = ON;
            end else begin
               g_d = up_sum[GAIN_W-1:0];
            end
         end
         ON: begin
            if (!enable) state_d = RAMP_DOWN;
         end
         RAMP_DOWN: begin
            if (enable) begin
               state_d = RAMP_UP;
            end else if (step_eff >= {1'b0, g_q}) begin
               g_d     = '0;
               state_d = IDLE;
            end else begin
               g_d = g_q - step_eff[GAIN_W-1:0];
            end
         end
         default: begin
            state_d = IDLE;
            g_d     = '0;
         end
      endcase
   end

   // FSM, gain and valid pipeline; input is always valid so valids fill with 1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         g_q      <= '0;
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else if (adv) begin
         state_q  <= state_d;
         g_q      <= g_d;
         vld_p1_q <= 1'b1;
         vld_p2_q <= vld_p1_q;
      end
   end

`ifdef DAC_RAMP_GATE_DROP_CNT_EN
   logic [15:0] drop_q;

   // Count input cycles lost to backpressure, sticking at full scale.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drop_q <= '0;
      end else if (!adv && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   assign drop_count = drop_q;
`else
   assign drop_count = '0;
`endif

   for (genvar i = 0; i < NUMBER_OF_LINE; i++) begin : g_lane
      dac_lane_scale u_lane (
         .clk_i  (clock),
         .rst_ni (reset_n),
         .adv_i  (adv),
         .din_i  (din[16*i +: 16]),
         .gain_i (g_q),
         .dout_o (m_axis_tdata[16*i +: 16])
      );
   end

   assign m_axis_tvalid = vld_p2_q;
   assign gate_state    = state_q;

endmodule

// File: tb/tb_dac_ramp_gate.sv
// Directed bench for dac_ramp_gate with hand-computed expected values.
module tb_dac_ramp_gate;
   import dac_ramp_gate_pkg::*;

   localparam int NL = 8;
   localparam int DW = 16*NL;

`ifdef DAC_RAMP_GATE_DROP_CNT_EN
   localparam logic [15:0] DROP_EXP = 16'd10;
`else
   localparam logic [15:0] DROP_EXP = 16'd0;
`endif

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] din;
   logic          enable;
   logic [15:0]   ramp_step;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [1:0]    gate_state;
   logic [15:0]   drop_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   dac_ramp_gate #(.NUMBER_OF_LINE(NL)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .din           (din),
      .enable        (enable),
      .ramp_step     (ramp_step),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .gate_state    (gate_state),
      .drop_count    (drop_count)
   );

   function automatic logic [DW-1:0] rep(input logic [15:0] v);
      return {NL{v}};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s", tag);
      end
   endtask

   // Output after ramp-up edge n (index 2..11), din = 0x4000, step = 4096.
   int up_exp[2:11] = '{0, 0, 2048, 4096, 6144, 8192, 10240, 12288, 14336, 16384};
   // Reversal at g = 12288: edges G5..G10.
   int rev_out[0:5] = '{4096, 6144, 6144, 4096, 2048, 0};
   logic [1:0] rev_st[0:5];
   logic [DW-1:0] alt;

   initial begin
      rev_st = '{RAMP_DOWN, RAMP_DOWN, RAMP_DOWN, IDLE, IDLE, IDLE};
      for (int i = 0; i < NL; i++) alt[16*i +: 16] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;

      din = rep(16'h4000);
      enable = 1'b0;
      ramp_step = 16'd4096;
      m_axis_tready = 1'b1;
      tick();
      tick();
      chk("rst_state", DW'(gate_state), DW'(IDLE));
      chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
      chk("rst_tdata", m_axis_tdata, '0);
      chk("rst_drop", DW'(drop_count), '0);

      // Ramp up from reset
      reset_n = 1'b1;
      enable = 1'b1;
      tick();
      chk("e1_state", DW'(gate_state), DW'(RAMP_UP));
      chk("e1_tvalid", DW'(m_axis_tvalid), DW'(0));
      for (int n = 2; n <= 11; n++) begin
         tick();
         chk($sformatf("up_state_%0d", n), DW'(gate_state), DW'((n <= 8) ? RAMP_UP : ON));
         chk($sformatf("up_data_%0d", n), m_axis_tdata, rep(16'(up_exp[n])));
         if (n == 2) chk("up_tvalid", DW'(m_axis_tvalid), DW'(1));
      end

      // Full-scale extremes at unity gain
      din = alt;
      tick();
      tick();
      chk("alt_extremes", m_axis_tdata, alt);

      // Full ramp down from ON
      din = rep(16'h4000);
      enable = 1'b0;
      tick();
      chk("dn_state_f1", DW'(gate_state), DW'(RAMP_DOWN));
      repeat (7) tick();
      chk("dn_state_f8", DW'(gate_state), DW'(RAMP_DOWN));
      tick();
      chk("dn_state_f9", DW'(gate_state), DW'(IDLE));
      tick();
      tick();
      chk("dn_data_zero", m_axis_tdata, '0);

      // Reverse mid ramp-up at g = 12288
      enable = 1'b1;
      repeat (4) tick();
      chk("rev_state_g4", DW'(gate_state), DW'(RAMP_UP));
      chk("rev_data_g4", m_axis_tdata, rep(16'd2048));
      enable = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("rev_state_%0d", k), DW'(gate_state), DW'(rev_st[k]));
         chk($sformatf("rev_data_%0d", k), m_axis_tdata, rep(16'(rev_out[k])));
      end

      // Backpressure while ON
      enable = 1'b1;
      repeat (11) tick();
      chk("bp_on_state", DW'(gate_state), DW'(ON));
      chk("bp_on_data", m_axis_tdata, rep(16'h4000));
      chk("bp_drop_pre", DW'(drop_count), '0);
      din = rep(16'h1000);
      tick();
      chk("bp_s1_data", m_axis_tdata, rep(16'h4000));
      m_axis_tready = 1'b0;
      din = rep(16'h2000);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("bp_hold_data_%0d", k), m_axis_tdata, rep(16'h4000));
         chk($sformatf("bp_hold_vld_%0d", k), DW'(m_axis_tvalid), DW'(1));
      end
      chk("bp_drop", DW'(drop_count), DW'(DROP_EXP));
      m_axis_tready = 1'b1;
      din = rep(16'h3000);
      tick();
      chk("bp_rel_1", m_axis_tdata, rep(16'h1000));
      tick();
      chk("bp_rel_2", m_axis_tdata, rep(16'h3000));
      chk("bp_drop_post", DW'(drop_count), DW'(DROP_EXP));

      // Reset in the middle of a ramp-down
      din = rep(16'h4000);
      enable = 1'b0;
      repeat (3) tick();
      chk("mr_state_pre", DW'(gate_state), DW'(RAMP_DOWN));
      #2;
      reset_n = 1'b0;
      #1;
      chk("mr_tvalid", DW'(m_axis_tvalid), DW'(0));
      chk("mr_tdata", m_axis_tdata, '0);
      chk("mr_state", DW'(gate_state), DW'(IDLE));
      chk("mr_drop", DW'(drop_count), '0);
      tick();

      // Zero step behaves as step 1
      reset_n = 1'b1;
      ramp_step = 16'd0;
      enable = 1'b1;
      tick();
      chk("z_k1_state", DW'(gate_state), DW'(RAMP_UP));
      chk("z_k1_tvalid", DW'(m_axis_tvalid), DW'(0));
      repeat (3) tick();
      chk("z_k4_data", m_axis_tdata, rep(16'd1));
      tick();
      chk("z_k5_data", m_axis_tdata, rep(16'd1));
      tick();
      chk("z_k6_data", m_axis_tdata, rep(16'd2));
      repeat (32768 - 6) tick();
      chk("z_k32768_state", DW'(gate_state), DW'(RAMP_UP));
      tick();
      chk("z_k32769_state", DW'(gate_state), DW'(ON));
      tick();
      tick();
      chk("z_unity_data", m_axis_tdata, rep(16'h4000));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
